// File: rtl/rf_bypass_scoreboard_pkg.sv
// Shared widths and the operand-source encoding for the decode-stage bypass network.
package rf_bypass_scoreboard_pkg;

    localparam int unsigned REG_WIDTH  = 5;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_FWD,
        SRC_CPL,
        SRC_RF,
        SRC_STALL
    } fwd_src_e;

endpackage

// File: rtl/rf_bypass_port_sel.sv
// Per-read-port priority mux: zero reg, in-flight stages, long-latency writeback,
// scoreboard hazard, register file.
module rf_bypass_port_sel #(
    parameter int unsigned NUM_FWD_STAGES = 3,
    parameter int unsigned REG_WIDTH      = 5,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                                 rd_en,
    input  logic [REG_WIDTH-1:0]                 rd_addr,
    input  logic [DATA_WIDTH-1:0]                rf_data,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_en,
    input  logic [NUM_FWD_STAGES*REG_WIDTH-1:0]  fwd_addr,
    input  logic [NUM_FWD_STAGES*DATA_WIDTH-1:0] fwd_data,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_valid,
    input  logic                                 cpl_en,
    input  logic [REG_WIDTH-1:0]                 cpl_addr,
    input  logic [DATA_WIDTH-1:0]                cpl_data,
    input  logic                                 busy,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 stall
);
    import rf_bypass_scoreboard_pkg::*;

    fwd_src_e              src;
    logic                  fwd_hit;
    logic                  fwd_hit_valid;
    logic [DATA_WIDTH-1:0] fwd_hit_data;

    always_comb begin
        fwd_hit       = 1'b0;
        fwd_hit_valid = 1'b0;
        fwd_hit_data  = '0;
        // Walk oldest to youngest so the youngest matching writer overrides.
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_en[k] && fwd_addr[k*REG_WIDTH +: REG_WIDTH] == rd_addr) begin
                fwd_hit       = 1'b1;
                fwd_hit_valid = fwd_valid[k];
                fwd_hit_data  = fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (!rd_en || rd_addr == '0) begin
            src = SRC_ZERO;
        end else if (fwd_hit) begin
            src = SRC_FWD;
        end else if (cpl_en && cpl_addr == rd_addr) begin
            src = SRC_CPL;
        end else if (busy) begin
            src = SRC_STALL;
        end else begin
            src = SRC_RF;
        end
    end

    always_comb begin
        rd_data = '0;
        stall   = 1'b0;
        unique case (src)
            SRC_ZERO: ;
            SRC_FWD: begin
                rd_data = fwd_hit_data;
                stall   = !fwd_hit_valid;
            end
            SRC_CPL:   rd_data = cpl_data;
            SRC_RF:    rd_data = rf_data;
            SRC_STALL: stall   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_bypass_scoreboard.sv
// Multi-port operand forwarding with a per-register scoreboard for long-latency writers,
// plus occupancy, overflow and stall-cycle bookkeeping.
module rf_bypass_scoreboard #(
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter int unsigned NUM_FWD_STAGES = 3,
    parameter int unsigned REG_WIDTH      = rf_bypass_scoreboard_pkg::REG_WIDTH,
    parameter int unsigned DATA_WIDTH     = rf_bypass_scoreboard_pkg::DATA_WIDTH,
    parameter int unsigned MAX_PENDING    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RD_PORTS-1:0]              rd_en,
    input  logic [NUM_RD_PORTS*REG_WIDTH-1:0]    rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0]    rf_addr,
    input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rf_data,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_en,
    input  logic [NUM_FWD_STAGES*REG_WIDTH-1:0]  fwd_addr,
    input  logic [NUM_FWD_STAGES*DATA_WIDTH-1:0] fwd_data,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_valid,
    input  logic                                 iss_en,
    input  logic [REG_WIDTH-1:0]                 iss_addr,
    input  logic                                 cpl_en,
    input  logic [REG_WIDTH-1:0]                 cpl_addr,
    input  logic [DATA_WIDTH-1:0]                cpl_data,
    input  logic                                 flush,
    output logic                                 stall,
    output logic                                 pend_full,
    output logic                                 ovf_err,
    output logic [31:0]                          stall_cnt
);

    localparam int unsigned NUM_REGS  = 2 ** REG_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PENDING);

    logic [NUM_REGS-1:0]     busy_q, busy_d;
    logic [CNT_WIDTH-1:0]    pend_cnt_q, pend_cnt_d;
    logic                    pend_full_q, pend_full_d;
    logic                    ovf_err_q, ovf_err_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;
    logic [NUM_RD_PORTS-1:0] port_stall;

    assign rf_addr = rd_addr;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [REG_WIDTH-1:0] addr;
        assign addr = rd_addr[p*REG_WIDTH +: REG_WIDTH];

        rf_bypass_port_sel #(
            .NUM_FWD_STAGES (NUM_FWD_STAGES),
            .REG_WIDTH      (REG_WIDTH),
            .DATA_WIDTH     (DATA_WIDTH)
        ) u_sel (
            .rd_en     (rd_en[p]),
            .rd_addr   (addr),
            .rf_data   (rf_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .fwd_en    (fwd_en),
            .fwd_addr  (fwd_addr),
            .fwd_data  (fwd_data),
            .fwd_valid (fwd_valid),
            .cpl_en    (cpl_en),
            .cpl_addr  (cpl_addr),
            .cpl_data  (cpl_data),
            .busy      (busy_q[addr]),
            .rd_data   (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .stall     (port_stall[p])
        );
    end

    assign stall = |port_stall;

    logic iss_req, iss_waw, cpl_hit, cpl_same, cpl_take, iss_take, ovf_set;

    always_comb begin
        iss_req  = iss_en && (iss_addr != '0);
        iss_waw  = iss_req && busy_q[iss_addr];
        cpl_hit  = cpl_en && busy_q[cpl_addr];
        cpl_same = cpl_hit && iss_req && (cpl_addr == iss_addr);
        cpl_take = cpl_hit && !cpl_same;
        // A completion in the same cycle frees the slot a full scoreboard needs.
        iss_take = iss_req && !iss_waw && (!pend_full_q || cpl_take);
        ovf_set  = iss_req && pend_full_q && !cpl_hit;

        busy_d     = busy_q;
        pend_cnt_d = pend_cnt_q;
        if (flush) begin
            busy_d     = '0;
            pend_cnt_d = '0;
        end else begin
            if (cpl_take) begin
                busy_d[cpl_addr] = 1'b0;
                pend_cnt_d       = pend_cnt_d - CNT_WIDTH'(1);
            end
            if (iss_take) begin
                busy_d[iss_addr] = 1'b1;
                pend_cnt_d       = pend_cnt_d + CNT_WIDTH'(1);
            end
        end

        pend_full_d = (pend_cnt_d == CNT_MAX);
        ovf_err_d   = ovf_err_q | (ovf_set && !flush);
        stall_cnt_d = (stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1
                                                               : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            pend_cnt_q  <= '0;
            pend_full_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            pend_cnt_q  <= pend_cnt_d;
            pend_full_q <= pend_full_d;
            ovf_err_q   <= ovf_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pend_full = pend_full_q;
    assign ovf_err   = ovf_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_bypass_scoreboard.sv
// Bench for rf_bypass_scoreboard: read-path vector table plus scoreboard sequences.
module tb_rf_bypass_scoreboard;

    localparam int unsigned NP = 2;
    localparam int unsigned NF = 3;
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;
    localparam logic [31:0] RF0 = 32'hA0;
    localparam logic [31:0] RF1 = 32'hB0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    rd_en;
    logic [NP*RW-1:0] rd_addr, rf_addr;
    logic [NP*DW-1:0] rd_data, rf_data;
    logic [NF-1:0]    fwd_en, fwd_valid;
    logic [NF*RW-1:0] fwd_addr;
    logic [NF*DW-1:0] fwd_data;
    logic             iss_en, cpl_en, flush;
    logic [RW-1:0]    iss_addr, cpl_addr;
    logic [DW-1:0]    cpl_data;
    logic             stall, pend_full, ovf_err;
    logic [31:0]      stall_cnt;

    always #5 clk = ~clk;

    rf_bypass_scoreboard #(
        .NUM_RD_PORTS   (NP),
        .NUM_FWD_STAGES (NF),
        .REG_WIDTH      (RW),
        .DATA_WIDTH     (DW),
        .MAX_PENDING    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .fwd_en    (fwd_en),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .fwd_valid (fwd_valid),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .cpl_en    (cpl_en),
        .cpl_addr  (cpl_addr),
        .cpl_data  (cpl_data),
        .flush     (flush),
        .stall     (stall),
        .pend_full (pend_full),
        .ovf_err   (ovf_err),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0, a1;
        logic [2:0]  fen, fval;
        logic [14:0] faddr;
        logic [95:0] fdata;
        logic        cen;
        logic [4:0]  caddr;
        logic [31:0] cdata;
        logic [31:0] e0, e1;
        logic        est;
    } vec_t;

    typedef struct {
        logic [31:0] d0, d1;
        logic        st;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        vt[9];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_sc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; rf_data = {RF1, RF0};
        fwd_en = '0; fwd_addr = '0; fwd_data = '0; fwd_valid = '0;
        iss_en = 1'b0; iss_addr = '0; cpl_en = 1'b0; cpl_addr = '0; cpl_data = '0;
        flush = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*RW +: RW] = a;
    endtask

    // Pop the expectation for this cycle and compare mid-cycle, away from the edge.
    task automatic tick(input string name);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no expectation queued", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, ".d0"}, rd_data[31:0], e.d0);
            chk({name, ".d1"}, rd_data[63:32], e.d1);
            chk({name, ".stall"}, {31'b0, stall}, {31'b0, e.st});
            chk({name, ".rf_addr"}, {22'b0, rf_addr}, {22'b0, rd_addr});
            if (e.st) exp_sc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string name, input logic [31:0] d0, input logic [31:0] d1,
                         input logic st);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.st = st;
        exp_q.push_back(e);
        tick(name);
    endtask

    initial begin
        vt[0] = '{2'b00, 5'd5, 5'd6, 3'b001, 3'b001, {5'd0, 5'd0, 5'd5},
                  {32'h0, 32'h0, 32'h11}, 1'b0, '0, '0, 32'h0, 32'h0, 1'b0};
        vt[1] = '{2'b11, 5'd5, 5'd6, 3'b011, 3'b011, {5'd0, 5'd5, 5'd5},
                  {32'h0, 32'h22, 32'h11}, 1'b0, '0, '0, 32'h11, RF1, 1'b0};
        vt[2] = '{2'b11, 5'd5, 5'd9, 3'b110, 3'b110, {5'd5, 5'd5, 5'd0},
                  {32'h33, 32'h22, 32'h0}, 1'b0, '0, '0, 32'h22, RF1, 1'b0};
        vt[3] = '{2'b11, 5'd0, 5'd0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd0},
                  {32'h0, 32'h0, 32'hFF}, 1'b1, 5'd0, 32'h55, 32'h0, 32'h0, 1'b0};
        vt[4] = '{2'b10, 5'd0, 5'd7, 3'b011, 3'b010, {5'd0, 5'd7, 5'd7},
                  {32'h0, 32'h66, 32'h77}, 1'b0, '0, '0, 32'h0, 32'h77, 1'b1};
        vt[5] = '{2'b10, 5'd0, 5'd7, 3'b010, 3'b010, {5'd0, 5'd7, 5'd0},
                  {32'h0, 32'h77, 32'h0}, 1'b0, '0, '0, 32'h0, 32'h77, 1'b0};
        vt[6] = '{2'b01, 5'd12, 5'd0, 3'b000, 3'b000, '0,
                  '0, 1'b1, 5'd12, 32'hC0DE, 32'hC0DE, 32'h0, 1'b0};
        vt[7] = '{2'b01, 5'd12, 5'd0, 3'b100, 3'b100, {5'd12, 5'd0, 5'd0},
                  {32'h2222, 32'h0, 32'h0}, 1'b1, 5'd12, 32'hC0DE, 32'h2222, 32'h0, 1'b0};
        vt[8] = '{2'b11, 5'd3, 5'd4, 3'b010, 3'b000, {5'd0, 5'd3, 5'd0},
                  {32'h0, 32'h3333, 32'h0}, 1'b0, '0, '0, 32'h3333, RF1, 1'b1};

        idle();
        rd(0, 5'd5);
        #12;
        chk("rst.pend_full", {31'b0, pend_full}, 32'd0);
        chk("rst.ovf_err", {31'b0, ovf_err}, 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        chk("rst.stall", {31'b0, stall}, 32'd0);
        chk("rst.rd_data0", rd_data[31:0], RF0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            idle();
            rd_en = vt[i].en; rd_addr = {vt[i].a1, vt[i].a0};
            fwd_en = vt[i].fen; fwd_valid = vt[i].fval;
            fwd_addr = vt[i].faddr; fwd_data = vt[i].fdata;
            cpl_en = vt[i].cen; cpl_addr = vt[i].caddr; cpl_data = vt[i].cdata;
            apply($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].est);
        end
        chk("vec.stall_cnt", stall_cnt, exp_sc);

        // Long-latency write to r9, forwarded on completion.
        idle(); iss_en = 1'b1; iss_addr = 5'd9;
        apply("p3.iss", 32'h0, 32'h0, 1'b0);
        idle(); rd(0, 5'd9);
        apply("p3.wait_a", 32'h0, 32'h0, 1'b1);
        apply("p3.wait_b", 32'h0, 32'h0, 1'b1);
        cpl_en = 1'b1; cpl_addr = 5'd9; cpl_data = 32'hDEAD;
        apply("p3.cpl", 32'hDEAD, 32'h0, 1'b0);
        cpl_en = 1'b0;
        apply("p3.rf", RF0, 32'h0, 1'b0);
        chk("p3.stall_cnt", stall_cnt, exp_sc);

        // Fill, overflow, and completion freeing a slot for a full-time issue.
        for (int r = 1; r <= 4; r++) begin
            idle(); iss_en = 1'b1; iss_addr = 5'(r);
            apply($sformatf("p4.iss%0d", r), 32'h0, 32'h0, 1'b0);
            chk($sformatf("p4.full%0d", r), {31'b0, pend_full}, (r == 4) ? 32'd1 : 32'd0);
        end
        idle(); iss_en = 1'b1; iss_addr = 5'd6;
        apply("p4.ovf_iss", 32'h0, 32'h0, 1'b0);
        chk("p4.ovf_err", {31'b0, ovf_err}, 32'd1);
        chk("p4.still_full", {31'b0, pend_full}, 32'd1);
        idle(); rd(0, 5'd6);
        apply("p4.r6_free", RF0, 32'h0, 1'b0);
        idle(); rd(0, 5'd6); rd(1, 5'd1);
        iss_en = 1'b1; iss_addr = 5'd6; cpl_en = 1'b1; cpl_addr = 5'd1; cpl_data = 32'h1111;
        apply("p4.iss_cpl", RF0, 32'h1111, 1'b0);
        chk("p4.full_after_swap", {31'b0, pend_full}, 32'd1);
        idle(); rd(0, 5'd6); rd(1, 5'd1);
        apply("p4.r6_busy", 32'h0, RF1, 1'b1);

        // Same-address issue+complete keeps the entry; count proven by one later completion.
        idle(); rd(0, 5'd3);
        iss_en = 1'b1; iss_addr = 5'd3; cpl_en = 1'b1; cpl_addr = 5'd3; cpl_data = 32'h3;
        apply("p5.same", 32'h3, 32'h0, 1'b0);
        chk("p5.full", {31'b0, pend_full}, 32'd1);
        idle(); rd(0, 5'd3);
        apply("p5.r3_busy", 32'h0, 32'h0, 1'b1);
        idle(); cpl_en = 1'b1; cpl_addr = 5'd4;
        apply("p5.cpl4", 32'h0, 32'h0, 1'b0);
        chk("p5.not_full", {31'b0, pend_full}, 32'd0);

        // Flush wins over a same-cycle issue and clears every entry.
        idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd8;
        apply("p6.flush", 32'h0, 32'h0, 1'b0);
        idle(); rd(0, 5'd2); rd(1, 5'd8);
        apply("p6.clear", RF0, RF1, 1'b0);
        chk("p6.ovf_sticky", {31'b0, ovf_err}, 32'd1);
        for (int r = 1; r <= 4; r++) begin
            idle(); iss_en = 1'b1; iss_addr = 5'(r);
            apply($sformatf("p6.iss%0d", r), 32'h0, 32'h0, 1'b0);
            chk($sformatf("p6.full%0d", r), {31'b0, pend_full}, (r == 4) ? 32'd1 : 32'd0);
        end
        idle(); rd(0, 5'd1);
        apply("p6.stall_a", 32'h0, 32'h0, 1'b1);
        apply("p6.stall_b", 32'h0, 32'h0, 1'b1);
        chk("p6.stall_cnt", stall_cnt, exp_sc);

        // Asynchronous reset while a read is stalled.
        #2 rst_n = 1'b0;
        #1;
        chk("arst.stall_cnt", stall_cnt, 32'd0);
        chk("arst.pend_full", {31'b0, pend_full}, 32'd0);
        chk("arst.ovf_err", {31'b0, ovf_err}, 32'd0);
        chk("arst.stall", {31'b0, stall}, 32'd0);
        chk("arst.rd_data0", rd_data[31:0], RF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
